branch_target_pipe: RTL and testbench

//  Parametrised, pipelined branch/jump target generator for the pipelined CPU.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/bt_split_adder.sv | 153 +++++++++++++++
 rtl/branch_target_pipe.sv | 84 ++++++++
 tb/tb_branch_target_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the branch/jump target path.
//   BT_WIDTH  : default address width
//   bt_mode_e : target generation mode encoding
package cpu_pkg;

    localparam int BT_WIDTH = 32;

    typedef enum logic [1:0] {
        BT_PCREL  = 2'b00,
        BT_REGREL = 2'b01,
        BT_JUMP   = 2'b10,
        BT_RSVD   = 2'b11
    } bt_mode_e;

endpackage

// File: rtl/bt_split_adder.sv
// Pipelined adder with valid tracking, stall/flush and a side-band tag.
// STAGES=1: single registered add. STAGES=2: low half added in stage 1
// (sum_lo and carry registered with the upper operands), upper half plus
// carry added in stage 2. Both give bit-identical results.
// Ports:
//   clk, reset (async, active-low), stall, flush, in_valid
//   a, b       : operands (a unsigned address, b signed offset)
//   tag_in     : side-band bits carried with each entry
//   out_valid, sum, wrap (carry/borrow out of WIDTH bits), tag_out
module bt_split_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             wrap,
    output logic [TAG_W-1:0] tag_out
);

    logic advance;
    assign advance = !stall && !flush;

    generate
        if (STAGES == 1) begin : g_one
            logic             out_valid_q, out_valid_d;
            logic [WIDTH-1:0] sum_q, sum_d, sum_new;
            logic             wrap_q, wrap_d;
            logic [TAG_W-1:0] tag_q, tag_d;
            logic             carry;
            logic             load;

            always_comb begin
                {carry, sum_new} = {1'b0, a} + {1'b0, b};
                load        = advance && in_valid;
                out_valid_d = out_valid_q;
                if (flush)
                    out_valid_d = 1'b0;
                else if (!stall)
                    out_valid_d = in_valid;
                // A carry out with a positive offset, or no carry with a
                // negative one, means the target crossed 0 / 2^WIDTH.
                sum_d  = load ? sum_new : sum_q;
                wrap_d = load ? (carry ^ b[WIDTH-1]) : wrap_q;
                tag_d  = load ? tag_in : tag_q;
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    out_valid_q <= 1'b0;
                    sum_q       <= '0;
                    wrap_q      <= 1'b0;
                    tag_q       <= '0;
                end else begin
                    out_valid_q <= out_valid_d;
                    sum_q       <= sum_d;
                    wrap_q      <= wrap_d;
                    tag_q       <= tag_d;
                end
            end

            assign out_valid = out_valid_q;
            assign sum       = sum_q;
            assign wrap      = wrap_q;
            assign tag_out   = tag_q;
        end else begin : g_two
            localparam int HALF = WIDTH / 2;
            localparam int HW   = WIDTH - HALF;
            localparam int HW1  = HW + 1;

            logic             v1_q, v1_d;
            logic [HALF-1:0]  lo_q, lo_d, lo_new;
            logic             c1_q, c1_d, c_lo;
            logic [HW-1:0]    a_hi_q, a_hi_d, b_hi_q, b_hi_d;
            logic [TAG_W-1:0] tag1_q, tag1_d;

            logic             out_valid_q, out_valid_d;
            logic [WIDTH-1:0] sum_q, sum_d;
            logic [HW-1:0]    hi_new;
            logic             c_hi;
            logic             wrap_q, wrap_d;
            logic [TAG_W-1:0] tag_q, tag_d;
            logic             load1, load2;

            always_comb begin
                {c_lo, lo_new} = {1'b0, a[HALF-1:0]} + {1'b0, b[HALF-1:0]};
                {c_hi, hi_new} = {1'b0, a_hi_q} + {1'b0, b_hi_q} + HW1'(c1_q);
                load1 = advance && in_valid;
                load2 = advance && v1_q;

                v1_d        = v1_q;
                out_valid_d = out_valid_q;
                if (flush) begin
                    v1_d        = 1'b0;
                    out_valid_d = 1'b0;
                end else if (!stall) begin
                    v1_d        = in_valid;
                    out_valid_d = v1_q;
                end

                lo_d   = load1 ? lo_new : lo_q;
                c1_d   = load1 ? c_lo : c1_q;
                a_hi_d = load1 ? a[WIDTH-1:HALF] : a_hi_q;
                b_hi_d = load1 ? b[WIDTH-1:HALF] : b_hi_q;
                tag1_d = load1 ? tag_in : tag1_q;

                sum_d  = load2 ? {hi_new, lo_q} : sum_q;
                wrap_d = load2 ? (c_hi ^ b_hi_q[HW-1]) : wrap_q;
                tag_d  = load2 ? tag1_q : tag_q;
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    v1_q        <= 1'b0;
                    lo_q        <= '0;
                    c1_q        <= 1'b0;
                    a_hi_q      <= '0;
                    b_hi_q      <= '0;
                    tag1_q      <= '0;
                    out_valid_q <= 1'b0;
                    sum_q       <= '0;
                    wrap_q      <= 1'b0;
                    tag_q       <= '0;
                end else begin
                    v1_q        <= v1_d;
                    lo_q        <= lo_d;
                    c1_q        <= c1_d;
                    a_hi_q      <= a_hi_d;
                    b_hi_q      <= b_hi_d;
                    tag1_q      <= tag1_d;
                    out_valid_q <= out_valid_d;
                    sum_q       <= sum_d;
                    wrap_q      <= wrap_d;
                    tag_q       <= tag_d;
                end
            end

            assign out_valid = out_valid_q;
            assign sum       = sum_q;
            assign wrap      = wrap_q;
            assign tag_out   = tag_q;
        end
    endgenerate

endmodule

// File: rtl/branch_target_pipe.sv
// Pipelined branch/jump target generator between ID and the IF PC mux.
// Selects operands per mode, assembles pseudo-absolute jumps, and feeds a
// 1- or 2-stage adder; flags are gated to zero while out_valid is low.
// Ports:
//   clk, reset (async, active-low)
//   in_valid, stall, flush
//   mode  : 00 PC-rel, 01 reg-rel, 10 jump, 11 reserved (acts as PC-rel)
//   pc, rs, imm : operands
//   out_valid, target, wrap, misalign, bad_mode
module branch_target_pipe
    import cpu_pkg::*;
#(
    parameter int WIDTH     = BT_WIDTH,
    parameter int IMM_SHIFT = 2,
    parameter int STAGES    = 1,
    parameter int ALIGN     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] imm,
    output logic             out_valid,
    output logic [WIDTH-1:0] target,
    output logic             wrap,
    output logic             misalign,
    output logic             bad_mode
);

    logic [WIDTH-1:0] op_a, op_b;
    logic             rsvd_in;
    logic             add_valid, add_wrap, add_rsvd;
    logic [WIDTH-1:0] add_sum;

    // Jumps go through the adder with b=0 so they share the pipeline timing
    // and naturally report wrap=0.
    always_comb begin
        op_a    = pc;
        op_b    = imm << IMM_SHIFT;
        rsvd_in = 1'b0;
        case (bt_mode_e'(mode))
            BT_REGREL: begin
                op_a = rs;
                op_b = imm;
            end
            BT_JUMP: begin
                op_a = {pc[WIDTH-1:WIDTH-4], imm[WIDTH-7:0], 2'b00};
                op_b = '0;
            end
            BT_RSVD: rsvd_in = 1'b1;
            default: ;
        endcase
    end

    bt_split_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .TAG_W  (1)
    ) u_adder (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .a         (op_a),
        .b         (op_b),
        .tag_in    (rsvd_in),
        .out_valid (add_valid),
        .sum       (add_sum),
        .wrap      (add_wrap),
        .tag_out   (add_rsvd)
    );

    assign out_valid = add_valid;
    assign target    = add_sum;
    assign wrap      = add_valid & add_wrap;
    assign bad_mode  = add_valid & add_rsvd;
    assign misalign  = add_valid & (|add_sum[ALIGN-1:0]);

endmodule

// File: tb/tb_branch_target_pipe.sv
module tb_branch_target_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] pc = '0, rs = '0, imm = '0;

    logic        ov1, wr1, ma1, bm1, ov2, wr2, ma2, bm2;
    logic [31:0] tg1, tg2;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        v;
        logic [31:0] t;
        logic        w;
        logic        m;
        logic        b;
    } ent_t;

    ent_t m1, m2a, m2b;

    always #5 clk = ~clk;

    branch_target_pipe #(.WIDTH(32), .IMM_SHIFT(2), .STAGES(1), .ALIGN(2)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .mode(mode), .pc(pc), .rs(rs), .imm(imm),
        .out_valid(ov1), .target(tg1), .wrap(wr1), .misalign(ma1), .bad_mode(bm1));

    branch_target_pipe #(.WIDTH(32), .IMM_SHIFT(2), .STAGES(2), .ALIGN(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .mode(mode), .pc(pc), .rs(rs), .imm(imm),
        .out_valid(ov2), .target(tg2), .wrap(wr2), .misalign(ma2), .bad_mode(bm2));

    // Reference: target as an exact integer sum, wrap when it leaves [0, 2^32).
    function automatic ent_t ref_calc(input logic v, input logic [1:0] m,
                                      input logic [31:0] p, input logic [31:0] r,
                                      input logic [31:0] im);
        ent_t e;
        longint a, s;
        int off;
        logic [31:0] shifted;
        e = '0;
        e.v = v;
        if (m == 2'b10) begin
            e.t = {p[31:28], im[25:0], 2'b00};
            e.w = 1'b0;
        end else begin
            shifted = im << 2;
            a   = (m == 2'b01) ? longint'({32'b0, r}) : longint'({32'b0, p});
            off = (m == 2'b01) ? int'(im) : int'(shifted);
            s   = a + longint'(off);
            e.w = (s < 0) || (s >= 64'sh1_0000_0000);
            e.t = s[31:0];
        end
        e.m = (e.t[1:0] != 2'b00);
        e.b = (m == 2'b11);
        return e;
    endfunction

    task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] p,
                         input logic [31:0] r, input logic [31:0] im);
        in_valid = v; mode = m; pc = p; rs = r; imm = im;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 2'b01, 32'h1234_5677, 32'h1111_1111, 32'h3);
        #12;
        n_tests++;
        if ({ov1, tg1, wr1, ma1, bm1} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_s1 got=%h exp=0", {ov1, tg1, wr1, ma1, bm1});
        end
        n_tests++;
        if ({ov2, tg2, wr2, ma2, bm2} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_s2 got=%h exp=0", {ov2, tg2, wr2, ma2, bm2});
        end
        drive(1'b0, 2'b00, '0, '0, '0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_modes_s1();
        drive(1'b1, 2'b00, 32'h0040_0000, 32'h0, 32'h10);
        tick();
        n_tests++;
        if ({ov1, tg1, wr1, ma1, bm1} !== {1'b1, 32'h0040_0040, 3'b000}) begin
            n_fail++;
            $display("FAIL pcrel_basic got=%h exp=%h", {ov1, tg1, wr1, ma1, bm1}, {1'b1, 32'h0040_0040, 3'b000});
        end
        drive(1'b1, 2'b00, 32'h0000_0008, 32'h0, 32'hFFFF_FFFC);
        tick();
        n_tests++;
        if ({ov1, tg1, wr1, ma1, bm1} !== {1'b1, 32'hFFFF_FFF8, 3'b100}) begin
            n_fail++;
            $display("FAIL pcrel_wrap got=%h exp=%h", {ov1, tg1, wr1, ma1, bm1}, {1'b1, 32'hFFFF_FFF8, 3'b100});
        end
        drive(1'b1, 2'b01, 32'h0, 32'h0000_1001, 32'h0);
        tick();
        n_tests++;
        if ({ov1, tg1, wr1, ma1, bm1} !== {1'b1, 32'h0000_1001, 3'b010}) begin
            n_fail++;
            $display("FAIL regrel_misalign got=%h exp=%h", {ov1, tg1, wr1, ma1, bm1}, {1'b1, 32'h0000_1001, 3'b010});
        end
        drive(1'b1, 2'b10, 32'hA000_0000, 32'h0, 32'h0012_3456);
        tick();
        n_tests++;
        if ({ov1, tg1, wr1, ma1, bm1} !== {1'b1, 32'hA048_D158, 3'b000}) begin
            n_fail++;
            $display("FAIL jump got=%h exp=%h", {ov1, tg1, wr1, ma1, bm1}, {1'b1, 32'hA048_D158, 3'b000});
        end
        drive(1'b1, 2'b11, 32'h0040_0000, 32'h0, 32'h10);
        tick();
        n_tests++;
        if ({ov1, tg1, wr1, ma1, bm1} !== {1'b1, 32'h0040_0040, 3'b001}) begin
            n_fail++;
            $display("FAIL bad_mode got=%h exp=%h", {ov1, tg1, wr1, ma1, bm1}, {1'b1, 32'h0040_0040, 3'b001});
        end
        drive(1'b0, 2'b00, '0, '0, '0);
        tick();
        n_tests++;
        if ({ov1, wr1, ma1, bm1} !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_s1 got=%b exp=0000", {ov1, wr1, ma1, bm1});
        end
    endtask

    task automatic test_carry_split();
        drive(1'b1, 2'b00, 32'h0000_FFFC, 32'h0, 32'h1);
        tick();
        n_tests++;
        if (ov2 !== 1'b0) begin
            n_fail++;
            $display("FAIL split_latency got=%b exp=0", ov2);
        end
        drive(1'b0, 2'b00, '0, '0, '0);
        tick();
        n_tests++;
        if ({ov2, tg2, wr2, ma2, bm2} !== {1'b1, 32'h0001_0000, 3'b000}) begin
            n_fail++;
            $display("FAIL split_carry got=%h exp=%h", {ov2, tg2, wr2, ma2, bm2}, {1'b1, 32'h0001_0000, 3'b000});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q1[$], q2[$];
        logic [31:0] exp_t;
        for (int c = 0; c < 8; c++) begin
            if (c < 5) drive(1'b1, 2'b01, '0, 32'h1000 * (c + 1), 32'(c * 4));
            else       drive(1'b0, 2'b00, '0, '0, '0);
            tick();
            if (ov1) q1.push_back(tg1);
            if (ov2) q2.push_back(tg2);
        end
        n_tests++;
        if (q1.size() != 5 || q2.size() != 5) begin
            n_fail++;
            $display("FAIL b2b_count got=%0d/%0d exp=5/5", q1.size(), q2.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                exp_t = 32'h1000 * (i + 1) + 32'(i * 4);
                n_tests++;
                if (q1[i] !== exp_t || q2[i] !== exp_t) begin
                    n_fail++;
                    $display("FAIL b2b_order idx=%0d got=%h/%h exp=%h", i, q1[i], q2[i], exp_t);
                end
            end
        end
    endtask

    task automatic test_stall_flush();
        drive(1'b1, 2'b01, '0, 32'h2000, '0);
        tick();
        drive(1'b1, 2'b01, '0, 32'h3000, '0);
        tick();
        drive(1'b1, 2'b01, '0, 32'h4000, '0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({ov2, tg2} !== {1'b1, 32'h2000} || {ov1, tg1} !== {1'b1, 32'h3000}) begin
                n_fail++;
                $display("FAIL stall_hold cyc=%0d got=%h/%h exp=%h/%h", i, {ov1, tg1}, {ov2, tg2}, {1'b1, 32'h3000}, {1'b1, 32'h2000});
            end
        end
        stall = 1'b0;
        drive(1'b0, 2'b00, '0, '0, '0);
        tick();
        n_tests++;
        if ({ov2, tg2} !== {1'b1, 32'h3000} || ov1 !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_order got=%h s1v=%b exp=%h s1v=0", {ov2, tg2}, ov1, {1'b1, 32'h3000});
        end
        tick();
        n_tests++;
        if (ov2 !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_drop got=%b exp=0", ov2);
        end
        drive(1'b1, 2'b00, 32'h100, '0, 32'h1);
        tick();
        drive(1'b1, 2'b00, 32'h200, '0, 32'h1);
        tick();
        drive(1'b1, 2'b00, 32'h300, '0, 32'h1);
        stall = 1'b1;
        flush = 1'b1;
        tick();
        n_tests++;
        if ({ov1, ov2} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_stall got=%b exp=00", {ov1, ov2});
        end
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 2'b00, '0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({ov1, ov2, wr1, wr2, bm1, bm2} !== 6'b0) begin
                n_fail++;
                $display("FAIL flush_stale cyc=%0d got=%b exp=0", i, {ov1, ov2, wr1, wr2, bm1, bm2});
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 2'b11, 32'hFFFF_FFF0, '0, 32'h7);
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({ov1, tg1, wr1, ma1, bm1, ov2, tg2, wr2, ma2, bm2} !== 72'h0) begin
            n_fail++;
            $display("FAIL reset_async got=%h/%h exp=0/0", {ov1, tg1, wr1, ma1, bm1}, {ov2, tg2, wr2, ma2, bm2});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 2'b01, '0, 32'h0000_5000, 32'h4);
        tick();
        drive(1'b0, 2'b00, '0, '0, '0);
        n_tests++;
        if ({ov1, tg1} !== {1'b1, 32'h5004} || ov2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_s1 got=%h s2v=%b exp=%h s2v=0", {ov1, tg1}, ov2, {1'b1, 32'h5004});
        end
        tick();
        n_tests++;
        if ({ov2, tg2} !== {1'b1, 32'h5004} || ov1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_s2 got=%h s1v=%b exp=%h s1v=0", {ov2, tg2}, ov1, {1'b1, 32'h5004});
        end
    endtask

    task automatic test_random();
        ent_t e;
        logic [35:0] act1, act2;
        drive(1'b0, 2'b00, '0, '0, '0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        m1 = '0; m2a = '0; m2b = '0;
        for (int c = 0; c < 10000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 9) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            mode     = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       pc = 32'($urandom_range(0, 255));
                1:       pc = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
                default: pc = $urandom;
            endcase
            rs  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 64));
            imm = ($urandom_range(0, 1) == 0) ? $urandom : 32'(int'($urandom_range(0, 128)) - 64);
            @(posedge clk);
            e = ref_calc(in_valid, mode, pc, rs, imm);
            if (flush) begin
                m1.v = 1'b0; m2a.v = 1'b0; m2b.v = 1'b0;
            end else if (!stall) begin
                if (m2a.v) m2b = m2a;
                else       m2b.v = 1'b0;
                m2a = e;
                m1  = e;
            end
            #1;
            act1 = {ov1, ov1 ? tg1 : 32'h0, wr1, ma1, bm1};
            act2 = {ov2, ov2 ? tg2 : 32'h0, wr2, ma2, bm2};
            n_tests++;
            if (act1 !== (m1.v ? m1 : 36'h0)) begin
                n_fail++;
                $display("FAIL rand_s1 cyc=%0d got=%h exp=%h", c, act1, m1.v ? m1 : 36'h0);
            end
            n_tests++;
            if (act2 !== (m2b.v ? m2b : 36'h0)) begin
                n_fail++;
                $display("FAIL rand_s2 cyc=%0d got=%h exp=%h", c, act2, m2b.v ? m2b : 36'h0);
            end
        end
        drive(1'b0, 2'b00, '0, '0, '0);
        stall = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_modes_s1();
        test_carry_split();
        test_back_to_back();
        test_stall_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
